chip8_keypad_scanner: RTL



---
 rtl/chip8_keypad_scanner.sv | 138 +++++++++++++
 1 files changed

// File: rtl/chip8_keypad_scanner.sv
// rtl/chip8_keypad_scanner.sv - 4x4 keypad matrix scanner with frame debounce and newest-key register
// Feeds chip8 input_keys / newest_key_down and honours its clear handshake.
module chip8_keypad_scanner #(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic [15:0] input_keys,
  output logic [4:0]  newest_key_down,
  input  logic        clear_newest_key_down,
  output logic        key_event
);

  localparam int DIV_W = $clog2(SCAN_DIV + 1);
  localparam int STB_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [STB_W-1:0] STB_FULL = STB_W'(DEBOUNCE_FRAMES);

  logic [3:0]       sync1_q, sync2_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  logic [15:0]      raw_q, raw_d;
  logic [15:0]      prev_q, prev_d;
  logic             frame_done_q, frame_done_d;
  logic [STB_W-1:0] stable_q, stable_d;
  logic [15:0]      keys_q, keys_d;
  logic [4:0]       newest_q, newest_d;
  logic             event_q, event_d;

  logic [15:0]      mapped;
  logic [15:0]      new_press;
  logic [3:0]       lowest;

  // Matrix position (row, col) to CHIP-8 hex key
  function automatic logic [3:0] key_of(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_of = 4'h1;  4'h1: key_of = 4'h2;  4'h2: key_of = 4'h3;  4'h3: key_of = 4'hC;
      4'h4: key_of = 4'h4;  4'h5: key_of = 4'h5;  4'h6: key_of = 4'h6;  4'h7: key_of = 4'hD;
      4'h8: key_of = 4'h7;  4'h9: key_of = 4'h8;  4'hA: key_of = 4'h9;  4'hB: key_of = 4'hE;
      4'hC: key_of = 4'hA;  4'hD: key_of = 4'h0;  4'hE: key_of = 4'hB;  default: key_of = 4'hF;
    endcase
  endfunction

  // raw_q is indexed {row, col}, 1 = pressed
  always_comb begin
    mapped = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        mapped[key_of(2'(r), 2'(c))] = raw_q[4*r+c];
      end
    end
  end

  assign new_press = mapped & ~keys_q;

  always_comb begin
    lowest = 4'h0;
    for (int k = 15; k >= 0; k--) begin
      if (new_press[k]) lowest = 4'(k);
    end
  end

  always_comb begin
    div_d        = div_q + DIV_W'(1);
    col_d        = col_q;
    raw_d        = raw_q;
    frame_done_d = 1'b0;
    if (div_q == DIV_LAST) begin
      div_d        = '0;
      col_d        = col_q + 2'd1;
      frame_done_d = (col_q == 2'd3);
      for (int r = 0; r < 4; r++) begin
        raw_d[{2'(r), col_q}] = ~sync2_q[r];
      end
    end
  end

  // A same-cycle committed press overrides the clear request
  always_comb begin
    prev_d   = prev_q;
    stable_d = stable_q;
    keys_d   = keys_q;
    newest_d = clear_newest_key_down ? 5'd16 : newest_q;
    event_d  = 1'b0;
    if (frame_done_q) begin
      prev_d = raw_q;
      if (raw_q == prev_q) begin
        stable_d = (stable_q == STB_FULL) ? stable_q : stable_q + STB_W'(1);
      end else begin
        stable_d = STB_W'(1);
      end
      if (stable_d == STB_FULL) begin
        keys_d = mapped;
        if (new_press != 16'h0) begin
          newest_d = {1'b0, lowest};
          event_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 4'b1111;
      sync2_q      <= 4'b1111;
      div_q        <= '0;
      col_q        <= 2'd0;
      raw_q        <= '0;
      prev_q       <= '0;
      frame_done_q <= 1'b0;
      stable_q     <= '0;
      keys_q       <= '0;
      newest_q     <= 5'd16;
      event_q      <= 1'b0;
    end else begin
      sync1_q      <= row_in;
      sync2_q      <= sync1_q;
      div_q        <= div_d;
      col_q        <= col_d;
      raw_q        <= raw_d;
      prev_q       <= prev_d;
      frame_done_q <= frame_done_d;
      stable_q     <= stable_d;
      keys_q       <= keys_d;
      newest_q     <= newest_d;
      event_q      <= event_d;
    end
  end

  assign col_out         = ~(4'b0001 << col_q);
  assign input_keys      = keys_q;
  assign newest_key_down = newest_q;
  assign key_event       = event_q;

endmodule
